// File: rtl/wrapper_result_collector_if.sv
// -----------------------------------------------------------------------------
// wrapper_result_collector_if
// Purpose : start/done/read handshake bundle between the host-side result
//           collector (master) and the engine wrapper (slave).
// Signals :
//   start      master -> slave   one-cycle start pulse
//   read       master -> slave   read handshake, held for a fixed number of cycles
//   ready      slave  -> master  wrapper idle / FIFO empty
//   done       slave  -> master  wrapper has a result word available
//   fifo_data  slave  -> master  wrapper FIFO output word (DW bits)
// -----------------------------------------------------------------------------
interface wrapper_result_collector_if #(
    parameter int DW = 8
) ();
    logic          start;
    logic          read;
    logic          ready;
    logic          done;
    logic [DW-1:0] fifo_data;

    modport master (
        output start,
        output read,
        input  ready,
        input  done,
        input  fifo_data
    );

    modport slave (
        input  start,
        input  read,
        output ready,
        output done,
        output fifo_data
    );
endinterface

// File: rtl/wrapper_result_collector.sv
// -----------------------------------------------------------------------------
// wrapper_result_collector
// Purpose : Host-side master for the engine wrapper. A go request (accepted only
//           while idle and the wrapper is ready) pulses start, waits for done,
//           then drains every result word through the read handshake into a
//           local buffer. When the wrapper returns to ready, complete pulses.
// Ports   :
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   wr           wrapper handshake bundle (master modport): start, read out;
//                ready, done, fifo_data in
//   go           session request, sampled only in IDLE
//   rd_idx       host index into the local buffer
//   busy         high in every state except IDLE
//   complete     one-cycle pulse at the end of a session
//   count        words stored this session, saturates at DEPTH
//   overflow     sticky: a word arrived while the buffer was full
//   rd_data      buffer[rd_idx], combinational
//   checksum     running sum of all captured words (mod 2^DW)
// Build option:
//   CHECKSUM_EN  when defined, checksum accumulates every captured word
//                (including discarded overflow words); otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module wrapper_result_collector #(
    parameter int DW          = 8,
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    wrapper_result_collector_if.master wr,
    input  logic                       go,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic                       busy,
    output logic                       complete,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [DW-1:0]              rd_data,
    output logic [DW-1:0]              checksum
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        REQ,
        RELEASE,
        DRAIN,
        FINISH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [HW-1:0]   hold_cnt;
    logic [DW-1:0]   buffer [DEPTH];
    logic            accept;
    logic            capture;
    logic            buf_full;

    // Saturating increment: count never wraps past DEPTH.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == DEPTH_C) ? v : v + CW'(1);
    endfunction

    // Modular accumulate for the checksum.
    function automatic logic [DW-1:0] wrap_add(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        return a + b;
    endfunction

    assign accept   = (state == IDLE) && go && wr.ready;
    assign capture  = (state == REQ) && (hold_cnt == HOLD_LAST);
    assign buf_full = (count == DEPTH_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Moore outputs decoded from the registered state, so an asynchronous
    // reset drops start and read immediately.
    always_comb begin
        state_nxt = state;
        wr.start  = 1'b0;
        wr.read   = 1'b0;
        complete  = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (go && wr.ready) state_nxt = START;
            end
            START: begin
                wr.start  = 1'b1;
                state_nxt = RUN;
            end
            RUN, DRAIN: begin
                // done wins over ready; ready with no done in RUN is the
                // zero-word session.
                if (wr.done)       state_nxt = REQ;
                else if (wr.ready) state_nxt = FINISH;
            end
            REQ: begin
                wr.read = 1'b1;
                if (hold_cnt == HOLD_LAST) state_nxt = RELEASE;
            end
            RELEASE: begin
                state_nxt = DRAIN;
            end
            FINISH: begin
                complete  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Hold counter: 0..HOLD_CYCLES-1 while in REQ, cleared everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if ((state == REQ) && !capture) begin
            hold_cnt <= hold_cnt + HW'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    // Session bookkeeping: cleared on an accepted go, held after FINISH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (capture) begin
            count <= sat_inc(count);
            if (buf_full) overflow <= 1'b1;
        end
    end

    // Buffer storage is data only and is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (capture && !buf_full) begin
            buffer[count[AW-1:0]] <= wr.fifo_data;
        end
    end

    assign rd_data = buffer[rd_idx];

`ifdef CHECKSUM_EN
    logic [DW-1:0] sum;

    // Discarded overflow words still contribute to the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (accept) begin
            sum <= '0;
        end else if (capture) begin
            sum <= wrap_add(sum, wr.fifo_data);
        end
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_wrapper_result_collector.sv
module tb_wrapper_result_collector;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int HOLD  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic [3:0] rd_idx;
    logic       busy;
    logic       complete;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] rd_data;
    logic [7:0] checksum;

    wrapper_result_collector_if #(.DW(DW)) bus ();

    wrapper_result_collector #(
        .DW(DW), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .wr(bus), .go(go), .rd_idx(rd_idx),
        .busy(busy), .complete(complete), .count(count), .overflow(overflow),
        .rd_data(rd_data), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural wrapper: after start, waits lat_cfg cycles, then offers
    // each queued word with done; pops a word once read has come and gone.
    // ------------------------------------------------------------------
    logic [7:0] mq [$];
    logic [7:0] head_q;
    int         ph;
    int         lat;
    int         lat_cfg   = 0;
    bit         force_busy = 1'b0;

    assign bus.fifo_data = head_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ready <= 1'b1;
            bus.done  <= 1'b0;
            ph        <= 0;
            lat       <= 0;
            head_q    <= '0;
            mq.delete();
        end else begin
            case (ph)
                0: begin
                    bus.ready <= !force_busy;
                    if (bus.start) begin
                        bus.ready <= 1'b0;
                        lat       <= lat_cfg;
                        ph        <= 1;
                    end
                end
                1: begin
                    if (lat > 0) lat <= lat - 1;
                    else if (mq.size() > 0) begin
                        bus.done <= 1'b1;
                        head_q   <= mq[0];
                        ph       <= 2;
                    end else begin
                        bus.ready <= 1'b1;
                        ph        <= 0;
                    end
                end
                2: begin
                    if (bus.read) begin
                        bus.done <= 1'b0;
                        ph       <= 3;
                    end
                end
                3: begin
                    if (!bus.read) begin
                        if (mq.size() > 1) begin
                            bus.done <= 1'b1;
                            head_q   <= mq[1];
                            ph       <= 2;
                        end else begin
                            bus.ready <= 1'b1;
                            ph        <= 0;
                        end
                        mq.pop_front();
                    end
                end
                default: ph <= 0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Protocol monitor, sampled on the falling edge.
    // ------------------------------------------------------------------
    int start_cnt    = 0;
    int complete_cnt = 0;
    int read_words   = 0;
    int viol         = 0;
    int run_len      = 0;
    int gap          = 100;
    bit prev_start   = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            run_len    <= 0;
            gap        <= 100;
            prev_start <= 1'b0;
        end else begin
            prev_start <= bus.start;
            if (bus.start) start_cnt <= start_cnt + 1;
            if (bus.start && prev_start) viol <= viol + 1;
            if (complete) complete_cnt <= complete_cnt + 1;
            if (bus.read) begin
                if (run_len == 0) begin
                    read_words <= read_words + 1;
                    if (gap < 2) viol <= viol + 1;
                end
                run_len <= run_len + 1;
            end else begin
                if (run_len != 0 && run_len != HOLD) viol <= viol + 1;
                run_len <= 0;
                gap     <= (run_len != 0) ? 1 : ((gap < 100) ? gap + 1 : gap);
            end
        end
    end

    // Expected checksum of a session under the current build.
    function automatic logic [7:0] ref_sum(input logic [7:0] w[$]);
        logic [7:0] s = '0;
`ifdef CHECKSUM_EN
        foreach (w[i]) s = s + w[i];
`endif
        return s;
    endfunction

    // ------------------------------------------------------------------
    // One full session: load wrapper, pulse go, wait for complete, check.
    // ------------------------------------------------------------------
    task automatic run_session(input logic [7:0] w[$], input int exp_cnt, input bit exp_ovf,
                               input logic [7:0] exp_sum, input bit inject, input string tag);
        int b_start, b_cmp, b_rd, b_v;
        bit seen_read = 1'b0;
        bit finished  = 1'b0;
        b_start = start_cnt;
        b_cmp   = complete_cnt;
        b_rd    = read_words;
        b_v     = viol;
        @(negedge clk);
        mq      = w;
        lat_cfg = $urandom_range(0, 3);
        go      = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (complete_cnt > b_cmp) begin
                finished = 1'b1;
                break;
            end
            go = 1'b0;
            if (inject && (c == 2 || (bus.read && !seen_read))) go = 1'b1;
            if (bus.read) seen_read = 1'b1;
            @(negedge clk);
        end
        go = 1'b0;
        check({tag, "_finished"}, 64'(finished), 64'(1));
        @(negedge clk);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_count"}, 64'(count), 64'(exp_cnt));
        check({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
        check({tag, "_checksum"}, 64'(checksum), 64'(exp_sum));
        check({tag, "_starts"}, 64'(start_cnt - b_start), 64'(1));
        check({tag, "_completes"}, 64'(complete_cnt - b_cmp), 64'(1));
        check({tag, "_reads"}, 64'(read_words - b_rd), 64'(w.size()));
        check({tag, "_protocol"}, 64'(viol - b_v), 64'(0));
        for (int i = 0; i < exp_cnt; i++) begin
            rd_idx = 4'(i);
            #1;
            check({tag, "_rd_data"}, 64'(rd_data), 64'(w[i]));
        end
    endtask

    typedef struct packed {
        logic [4:0]       n;
        logic [19:0][7:0] w;
        logic [4:0]       exp_cnt;
        logic             exp_ovf;
        logic [7:0]       exp_sum;
    } vec_t;

    vec_t       tbl [5];
    logic [7:0] q [$];

    initial begin
        // Directed table: words, expected count/overflow/checksum (CHECKSUM_EN build).
        tbl[0] = '0; tbl[0].n = 5'd4;  tbl[0].exp_cnt = 5'd4;  tbl[0].exp_ovf = 1'b0; tbl[0].exp_sum = 8'hAA;
        tbl[0].w[0] = 8'h11; tbl[0].w[1] = 8'h22; tbl[0].w[2] = 8'h33; tbl[0].w[3] = 8'h44;
        tbl[1] = '0; tbl[1].n = 5'd20; tbl[1].exp_cnt = 5'd16; tbl[1].exp_ovf = 1'b1; tbl[1].exp_sum = 8'hD2;
        for (int i = 0; i < 20; i++) tbl[1].w[i] = 8'(i + 1);
        tbl[2] = '0; tbl[2].n = 5'd0;  tbl[2].exp_cnt = 5'd0;  tbl[2].exp_ovf = 1'b0; tbl[2].exp_sum = 8'h00;
        tbl[3] = '0; tbl[3].n = 5'd16; tbl[3].exp_cnt = 5'd16; tbl[3].exp_ovf = 1'b0; tbl[3].exp_sum = 8'h78;
        for (int i = 0; i < 16; i++) tbl[3].w[i] = 8'(8'hA0 + i);
        tbl[4] = '0; tbl[4].n = 5'd2;  tbl[4].exp_cnt = 5'd2;  tbl[4].exp_ovf = 1'b0; tbl[4].exp_sum = 8'h10;
        tbl[4].w[0] = 8'hF0; tbl[4].w[1] = 8'h20;

        rst    = 1'b1;
        go     = 1'b0;
        rd_idx = '0;
        repeat (3) @(negedge clk);
        check("rst_start", 64'(bus.start), 64'(0));
        check("rst_read", 64'(bus.read), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_complete", 64'(complete), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_checksum", 64'(checksum), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            logic [7:0] es;
            q.delete();
            for (int i = 0; i < int'(tbl[k].n); i++) q.push_back(tbl[k].w[i]);
`ifdef CHECKSUM_EN
            es = tbl[k].exp_sum;
`else
            es = 8'h00;
`endif
            run_session(q, int'(tbl[k].exp_cnt), tbl[k].exp_ovf, es, 1'b0, $sformatf("tbl%0d", k));
        end

        // go pulses during RUN and REQ must not start a second session.
        q = '{8'h5A, 8'hA5, 8'h3C};
        run_session(q, 3, 1'b0, ref_sum(q), 1'b1, "inject");

        // go in IDLE while the wrapper is not ready: no start.
        begin
            int b_start;
            force_busy = 1'b1;
            repeat (2) @(negedge clk);
            b_start = start_cnt;
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            repeat (5) @(negedge clk);
            check("notready_starts", 64'(start_cnt - b_start), 64'(0));
            check("notready_busy", 64'(busy), 64'(0));
            force_busy = 1'b0;
            repeat (2) @(negedge clk);
        end

        // Reset in the middle of the second word's read.
        begin
            int  b_rd;
            bit  hit = 1'b0;
            b_rd    = read_words;
            mq      = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
            lat_cfg = 0;
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (read_words - b_rd >= 2 && bus.read) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("midreq_reached", 64'(hit), 64'(1));
            #2 rst = 1'b1;
            #1;
            check("midreq_read", 64'(bus.read), 64'(0));
            check("midreq_start", 64'(bus.start), 64'(0));
            check("midreq_count", 64'(count), 64'(0));
            check("midreq_busy", 64'(busy), 64'(0));
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            repeat (2) @(negedge clk);
            q = '{8'hC3, 8'h7E};
            run_session(q, 2, 1'b0, ref_sum(q), 1'b0, "postrst");
        end

        // Randomized sessions against the reference rules.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(0, 22);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            run_session(q, (n < DEPTH) ? n : DEPTH, n > DEPTH, ref_sum(q), 1'($urandom_range(0, 1)),
                        $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
